// File: rtl/i2s_transmitter.sv
// Master-mode I2S transmitter: one-entry PCM holding register, BCLK/WS generation, mono word sent on both channels.
// Build option: define I2S_TX_HOLD_LAST_EN to repeat the previous word on underrun instead of sending silence.
module i2s_transmitter #(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int I2S_CLK_FREQ  = 1_500_000,
  parameter int DATA_IN_SIZE  = 16,
  parameter int I2S_DATA_SIZE = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_IN_SIZE-1:0] pcm_in,
  input  logic                    pcm_valid,
  output logic                    pcm_ready,
  output logic                    i2s_clk,
  output logic                    i2s_ws,
  output logic                    i2s_sd,
  output logic                    underrun
);

  localparam int DIV   = CLK_FREQ / (2 * I2S_CLK_FREQ);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PAD   = I2S_DATA_SIZE - DATA_IN_SIZE;
  localparam int IDX_W = (I2S_DATA_SIZE > 1) ? $clog2(I2S_DATA_SIZE) : 1;

  if (DIV < 1) begin : g_div_check
    $error("i2s_transmitter: CLK_FREQ / (2*I2S_CLK_FREQ) must be at least 1");
  end
  if (DATA_IN_SIZE > I2S_DATA_SIZE) begin : g_in_size_check
    $error("i2s_transmitter: DATA_IN_SIZE must not exceed I2S_DATA_SIZE");
  end
  if (I2S_DATA_SIZE > 31) begin : g_out_size_check
    $error("i2s_transmitter: I2S_DATA_SIZE must not exceed 31");
  end

  logic [DIV_W-1:0]         div_cnt_r;
  logic                     i2s_clk_r;
  logic [5:0]               bit_cnt_r;
  logic                     i2s_ws_r;
  logic                     i2s_sd_r;
  logic [I2S_DATA_SIZE-1:0] word_r;
  logic                     underrun_r;
  logic [DATA_IN_SIZE-1:0]  hold_r;
  logic                     hold_full_r;
  logic                     pcm_ready_r;

  logic                     div_last_s;
  logic                     fall_s;
  logic [5:0]               bit_nxt_s;
  logic                     frame_start_s;
  logic [4:0]               slot_s;
  logic [IDX_W-1:0]         sd_idx_s;
  logic                     sd_nxt_s;
  logic [I2S_DATA_SIZE-1:0] word_fmt_s;

  assign i2s_clk   = i2s_clk_r;
  assign i2s_ws    = i2s_ws_r;
  assign i2s_sd    = i2s_sd_r;
  assign underrun  = underrun_r;
  assign pcm_ready = pcm_ready_r;

  // Divider terminal count, BCLK falling-edge and frame-start strobes, data bit for the next slot.
  always_comb begin
    div_last_s    = (div_cnt_r == DIV_W'(DIV - 1));
    fall_s        = div_last_s & i2s_clk_r;
    bit_nxt_s     = bit_cnt_r + 6'd1;
    frame_start_s = fall_s & (bit_nxt_s == 6'd0);
    slot_s        = bit_nxt_s[4:0];
    sd_idx_s      = IDX_W'(I2S_DATA_SIZE) - IDX_W'(slot_s);
    word_fmt_s    = I2S_DATA_SIZE'(hold_r) << PAD;
    // Slot 0 carries the one-bit I2S delay; slots past the word are padding.
    if ((slot_s != 5'd0) && (6'(slot_s) <= 6'(I2S_DATA_SIZE))) begin
      sd_nxt_s = word_r[sd_idx_s];
    end else begin
      sd_nxt_s = 1'b0;
    end
  end

  // Bit-clock divider: i2s_clk toggles every DIV system clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= {DIV_W{1'b0}};
      i2s_clk_r <= 1'b0;
    end else if (div_last_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
      i2s_clk_r <= ~i2s_clk_r;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Slot sequencer: ws, sd and the frame word change only on a BCLK falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_r  <= 6'd63;
      i2s_ws_r   <= 1'b0;
      i2s_sd_r   <= 1'b0;
      word_r     <= {I2S_DATA_SIZE{1'b0}};
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= frame_start_s & ~hold_full_r;
      if (fall_s) begin
        bit_cnt_r <= bit_nxt_s;
        i2s_ws_r  <= bit_nxt_s[5];
        i2s_sd_r  <= sd_nxt_s;
      end
      if (frame_start_s) begin
        if (hold_full_r) begin
          word_r <= word_fmt_s;
        end else begin
`ifdef I2S_TX_HOLD_LAST_EN
          word_r <= word_r;
`else
          word_r <= {I2S_DATA_SIZE{1'b0}};
`endif
        end
      end
    end
  end

  // Holding register: a frame start only drains an already-full entry, so an accept in that cycle waits a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r      <= {DATA_IN_SIZE{1'b0}};
      hold_full_r <= 1'b0;
      pcm_ready_r <= 1'b1;
    end else if (frame_start_s && hold_full_r) begin
      hold_full_r <= 1'b0;
      pcm_ready_r <= 1'b1;
    end else if (pcm_valid && pcm_ready_r) begin
      hold_r      <= pcm_in;
      hold_full_r <= 1'b1;
      pcm_ready_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter at DIV = 2, 16 -> 24 bits: per-frame vector table plus reset and
// simultaneous-accept sequences. Expected words follow I2S_TX_HOLD_LAST_EN when it is defined.
module tb_i2s_transmitter;

  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pcm_in;
  logic        pcm_valid;
  logic        pcm_ready;
  logic        i2s_clk;
  logic        i2s_ws;
  logic        i2s_sd;
  logic        underrun;

  i2s_transmitter #(
    .CLK_FREQ     (4),
    .I2S_CLK_FREQ (1),
    .DATA_IN_SIZE (16),
    .I2S_DATA_SIZE(24)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pcm_in   (pcm_in),
    .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready),
    .i2s_clk  (i2s_clk),
    .i2s_ws   (i2s_ws),
    .i2s_sd   (i2s_sd),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pcm;
    bit          push;
    logic [23:0] exp_word;
    bit          exp_und;
    bit          exp_rdy;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          k;
  bit          fell;
  logic        prev_clk;
  int          und_cnt;
  int          ticks_since_fall;
  int          last_gap;
  int          feed_k;
  logic [15:0] src_q[$];
  logic [23:0] under_word;
  vec_t        vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One system clock: account for the accept at this edge, sample #1 later, then drive the source.
  task automatic tick();
    bit fired;
    fired = pcm_valid && pcm_ready;
    @(posedge clk);
    #1;
    k++;
    ticks_since_fall++;
    if (fired && src_q.size() > 0) void'(src_q.pop_front());
    fell     = prev_clk && !i2s_clk;
    prev_clk = i2s_clk;
    if (fell) begin
      last_gap         = ticks_since_fall;
      ticks_since_fall = 0;
    end
    if (underrun) und_cnt++;
    if (src_q.size() > 0 && k >= feed_k) begin
      pcm_valid = 1'b1;
      pcm_in    = src_q[0];
    end else begin
      pcm_valid = 1'b0;
    end
  endtask

  task automatic next_fall();
    int n;
    n    = 0;
    fell = 1'b0;
    while (!fell && n < 4 * DIV) begin
      tick();
      n++;
    end
    if (!fell) begin
      n_checks++;
      n_fail++;
      $display("FAIL fall_timeout: no BCLK falling edge within %0d cycles", 4 * DIV);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_bclk"}, 32'(i2s_clk), 32'd0);
    check({tag, "_ws"}, 32'(i2s_ws), 32'd0);
    check({tag, "_sd"}, 32'(i2s_sd), 32'd0);
    check({tag, "_underrun"}, 32'(underrun), 32'd0);
    check({tag, "_ready"}, 32'(pcm_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // After release: BCLK low for DIV cycles, high for DIV, first falling edge exactly at 2*DIV.
  task automatic post_reset(input string tag);
    k                = 0;
    prev_clk         = 1'b0;
    fell             = 1'b0;
    ticks_since_fall = 0;
    for (int n = 1; n <= 2 * DIV; n++) begin
      tick();
      check({tag, "_bclk_phase"}, 32'(i2s_clk), 32'((k / DIV) % 2));
    end
    check({tag, "_first_fall"}, 32'(fell), 32'd1);
  endtask

  // Capture one 64-slot frame starting at its frame-start falling edge and check it.
  task automatic capture_frame(input bit start_done, input string tag, input logic [23:0] exp_word,
                               input bit exp_und, input bit exp_rdy);
    logic [23:0] l, r;
    logic        und0, rdy_mid;
    bit          pad_ok, ws_ok, gap_ok;
    int          u0;
    l       = 24'h0;
    r       = 24'h0;
    und0    = 1'b0;
    rdy_mid = 1'b0;
    pad_ok  = 1'b1;
    ws_ok   = 1'b1;
    gap_ok  = 1'b1;
    u0      = und_cnt - ((start_done && underrun) ? 1 : 0);
    for (int s = 0; s < 64; s++) begin
      if (!(s == 0 && start_done)) next_fall();
      if (s == 0) und0 = underrun;
      else if (last_gap != 2 * DIV) gap_ok = 1'b0;
      if (i2s_ws !== s[5]) ws_ok = 1'b0;
      if ((s % 32) >= 1 && (s % 32) <= 24) begin
        if (s < 32) l = {l[22:0], i2s_sd};
        else r = {r[22:0], i2s_sd};
      end else if (i2s_sd !== 1'b0) begin
        pad_ok = 1'b0;
      end
      if (s == 32) rdy_mid = pcm_ready;
    end
    check({tag, "_left"}, 32'(l), 32'(exp_word));
    check({tag, "_right"}, 32'(r), 32'(exp_word));
    check({tag, "_underrun_at_start"}, 32'(und0), 32'(exp_und));
    check({tag, "_underrun_cycles"}, 32'(und_cnt - u0), 32'(exp_und));
    check({tag, "_ready_mid"}, 32'(rdy_mid), 32'(exp_rdy));
    check({tag, "_pad_zero"}, 32'(pad_ok), 32'd1);
    check({tag, "_ws_pattern"}, 32'(ws_ok), 32'd1);
    check({tag, "_bclk_period"}, 32'(gap_ok), 32'd1);
  endtask

  initial begin
    pcm_valid        = 1'b0;
    pcm_in           = 16'h0;
    feed_k           = 0;
    und_cnt          = 0;
    last_gap         = 0;
    ticks_since_fall = 0;
    k                = 0;
    prev_clk         = 1'b0;
    fell             = 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
    under_word = 24'h123400;
`else
    under_word = 24'h000000;
`endif
    vecs[0] = '{16'h0001, 1'b1, 24'h000100, 1'b0, 1'b0};
    vecs[1] = '{16'h8000, 1'b1, 24'h800000, 1'b0, 1'b0};
    vecs[2] = '{16'h7FFF, 1'b1, 24'h7FFF00, 1'b0, 1'b0};
    vecs[3] = '{16'h1234, 1'b1, 24'h123400, 1'b0, 1'b1};
    vecs[4] = '{16'h0000, 1'b0, under_word, 1'b1, 1'b1};
    vecs[5] = '{16'h0000, 1'b0, under_word, 1'b1, 1'b1};

    #2;
    do_reset("reset");
    post_reset("boot");

    // Frame 0 has nothing held; 0xA5C3 is accepted during it and sent in frame 1.
    src_q.push_back(16'hA5C3);
    capture_frame(1'b1, "frame0", 24'h000000, 1'b1, 1'b0);
    capture_frame(1'b0, "basic", 24'hA5C300, 1'b0, 1'b1);

    // Sample for frame i+1 is queued while frame i plays, keeping pcm_valid up back-to-back.
    if (vecs[0].push) src_q.push_back(vecs[0].pcm);
    for (int i = 0; i < 6; i++) begin
      if (i + 1 < 6 && vecs[i + 1].push) src_q.push_back(vecs[i + 1].pcm);
      capture_frame(1'b0, $sformatf("vec%0d", i), vecs[i].exp_word, vecs[i].exp_und, vecs[i].exp_rdy);
    end

    // Valid rises so that the accept lands exactly on the frame-start edge.
    feed_k = k + 2 * DIV - 1;
    src_q.push_back(16'h5555);
    capture_frame(1'b0, "simul", under_word, 1'b1, 1'b0);
    feed_k = 0;
    capture_frame(1'b0, "simul_next", 24'h555500, 1'b0, 1'b1);

    // Reset in the right channel at bit_cnt 40 with 0x3333 still held.
    src_q.push_back(16'hFFFF);
    src_q.push_back(16'h3333);
    for (int s = 0; s <= 40; s++) next_fall();
    repeat (DIV) tick();
    check("pre_rst_ws", 32'(i2s_ws), 32'd1);
    check("pre_rst_sd", 32'(i2s_sd), 32'd1);
    check("pre_rst_bclk", 32'(i2s_clk), 32'd1);
    check("pre_rst_ready", 32'(pcm_ready), 32'd0);
    do_reset("mid_reset");
    post_reset("rerun");
    capture_frame(1'b1, "post_rst", 24'h000000, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
